// File: rtl/rv32i_types.sv
// Shared RV32I types for the pipeline.
// Holds the machine word type, opcode and funct3 encodings, the control word
// carried down the pipeline, and the MEM-stage FSM state encoding.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef struct packed {
        rv32i_opcode opcode;
        logic [2:0]  funct3;
        logic        load_regfile;
        logic [4:0]  rd;
    } rv32i_control_word;

    // MEM stage: IDLE issues, WAIT holds the request until data_resp,
    // HOLD parks a response that arrived while the pipeline was frozen.
    typedef enum logic [1:0] {
        MEM_IDLE = 2'b00,
        MEM_WAIT = 2'b01,
        MEM_HOLD = 2'b10
    } mem_state_t;

    // Access size lives in funct3[1:0] for both loads and stores.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

endpackage

// File: rtl/mem_align.sv
// Store/load lane alignment (combinational).
// Ports:
//   funct3 - access size in funct3[1:0] (byte / half / word)
//   off    - byte offset within the word (effective address [1:0])
//   rs2    - store source data
//   mbe    - byte mask; halfword at offset 3 is truncated to 4'b1000
//   wdata  - store data shifted into its byte lanes, other lanes zero
module mem_align
    import rv32i_types::*;
(
    input  logic [2:0] funct3,
    input  logic [1:0] off,
    input  rv32i_word  rs2,
    output logic [3:0] mbe,
    output rv32i_word  wdata
);

    always_comb begin
        mbe   = 4'b1111;
        wdata = rs2;
        case (funct3[1:0])
            SIZE_BYTE: begin
                mbe   = 4'b0001 << off;
                wdata = {24'b0, rs2[7:0]} << {off, 3'b000};
            end
            SIZE_HALF: begin
                mbe   = 4'b0011 << off;
                wdata = {16'b0, rs2[15:0]} << {off, 3'b000};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// RV32I memory-access stage plus the MEM/WB pipeline register.
// Turns loads/stores into data-cache requests, stalls until data_resp,
// and parks a response that lands during an external freeze.
// Ports:
//   clk, rst (async, active low)
//   valid_i, pc_i, pc_plus4_i, instruction_i, ctrl_word_i, alu_i, rs2_i,
//   br_en_i                       - EX/MEM register contents
//   freeze                        - external global stall
//   data_read/write/addr/mbe/wdata, data_rdata, data_resp - cache port
//   stall_o                       - MEM cannot retire this cycle
//   wb_*                          - MEM/WB register
//   mem_state                     - current FSM state (debug)
// Cache handshake: a strobe, once raised for an instruction, stays high with
// stable address/mask/data until the single-cycle data_resp; the response
// completes exactly one transaction and the strobe drops afterwards.
module mem_access
    import rv32i_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  rv32i_word         pc_i,
    input  rv32i_word         pc_plus4_i,
    input  rv32i_word         instruction_i,
    input  rv32i_control_word ctrl_word_i,
    input  rv32i_word         alu_i,
    input  rv32i_word         rs2_i,
    input  rv32i_word         br_en_i,
    input  logic              freeze,
    output logic              data_read,
    output logic              data_write,
    output rv32i_word         data_addr,
    output logic [3:0]        data_mbe,
    output rv32i_word         data_wdata,
    input  rv32i_word         data_rdata,
    input  logic              data_resp,
    output logic              stall_o,
    output rv32i_word         wb_pc,
    output rv32i_word         wb_pc_plus4,
    output rv32i_word         wb_instruction,
    output rv32i_word         wb_alu,
    output rv32i_word         wb_br_en,
    output rv32i_word         wb_r_data,
    output rv32i_word         wb_w_data,
    output rv32i_word         wb_data_addr,
    output rv32i_control_word wb_ctrl_word,
    output logic [3:0]        wb_mbe,
    output mem_state_t        mem_state
);

    logic       is_load;
    logic       is_store;
    logic       mem_op;
    logic       req;
    logic       load_wb;
    logic [3:0] mbe;
    rv32i_word  wdata;
    rv32i_word  addr_aligned;
    rv32i_word  hold_buf;

    mem_align u_align (
        .funct3 (ctrl_word_i.funct3),
        .off    (alu_i[1:0]),
        .rs2    (rs2_i),
        .mbe    (mbe),
        .wdata  (wdata)
    );

    assign is_load      = valid_i && (ctrl_word_i.opcode == op_load);
    assign is_store     = valid_i && (ctrl_word_i.opcode == op_store);
    assign mem_op       = is_load || is_store;
    assign addr_aligned = {alu_i[31:2], 2'b00};

    // Gated by rst so the request vanishes the instant reset asserts,
    // even while EX/MEM still presents a memory instruction.
    always_comb begin
        req     = 1'b0;
        stall_o = 1'b0;
        if (rst) begin
            case (mem_state)
                MEM_IDLE: begin
                    req     = mem_op && !freeze;
                    stall_o = mem_op && !data_resp;
                end
                MEM_WAIT: begin
                    req     = mem_op;
                    stall_o = !data_resp;
                end
                default: ;
            endcase
        end
    end

    assign load_wb    = !stall_o && !freeze;
    assign data_read  = req && is_load;
    assign data_write = req && is_store;
    assign data_addr  = req ? addr_aligned : '0;
    assign data_mbe   = req ? mbe : 4'b0000;
    assign data_wdata = req ? wdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_state      <= MEM_IDLE;
            hold_buf       <= '0;
            wb_pc          <= '0;
            wb_pc_plus4    <= '0;
            wb_instruction <= '0;
            wb_alu         <= '0;
            wb_br_en       <= '0;
            wb_r_data      <= '0;
            wb_w_data      <= '0;
            wb_data_addr   <= '0;
            wb_ctrl_word   <= '0;
            wb_mbe         <= 4'b0000;
        end else begin
            case (mem_state)
                MEM_IDLE: begin
                    if (req && !data_resp) mem_state <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (data_resp) begin
                        if (freeze) begin
                            hold_buf  <= data_rdata;
                            mem_state <= MEM_HOLD;
                        end else begin
                            mem_state <= MEM_IDLE;
                        end
                    end
                end
                MEM_HOLD: begin
                    if (!freeze) mem_state <= MEM_IDLE;
                end
                default: mem_state <= MEM_IDLE;
            endcase

            if (load_wb) begin
                if (!valid_i) begin
                    wb_pc          <= '0;
                    wb_pc_plus4    <= '0;
                    wb_instruction <= '0;
                    wb_alu         <= '0;
                    wb_br_en       <= '0;
                    wb_ctrl_word   <= '0;
                    wb_r_data      <= '0;
                    wb_w_data      <= '0;
                    wb_data_addr   <= '0;
                    wb_mbe         <= 4'b0000;
                end else begin
                    wb_pc          <= pc_i;
                    wb_pc_plus4    <= pc_plus4_i;
                    wb_instruction <= instruction_i;
                    wb_alu         <= alu_i;
                    wb_br_en       <= br_en_i;
                    wb_ctrl_word   <= ctrl_word_i;
                    if (mem_op) begin
                        wb_r_data    <= (mem_state == MEM_HOLD) ? hold_buf : data_rdata;
                        wb_w_data    <= wdata;
                        wb_data_addr <= addr_aligned;
                        wb_mbe       <= mbe;
                    end else begin
                        wb_r_data    <= '0;
                        wb_w_data    <= '0;
                        wb_data_addr <= '0;
                        wb_mbe       <= 4'b0000;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: reset checks, a table of alignment vectors, hand
// sequences for freeze/reset corner cases, then randomized instructions
// checked cycle by cycle against a transaction-level model.
module tb_mem_access;
    import rv32i_types::*;

    localparam int WB_W = 276;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              valid_i = 1'b0;
    rv32i_word         pc_i = '0, pc_plus4_i = '0, instruction_i = '0;
    rv32i_control_word ctrl_word_i = '0;
    rv32i_word         alu_i = '0, rs2_i = '0, br_en_i = '0;
    logic              freeze = 1'b0;
    logic              data_read, data_write;
    rv32i_word         data_addr, data_wdata;
    logic [3:0]        data_mbe;
    rv32i_word         data_rdata = '0;
    logic              data_resp = 1'b0;
    logic              stall_o;
    rv32i_word         wb_pc, wb_pc_plus4, wb_instruction, wb_alu, wb_br_en;
    rv32i_word         wb_r_data, wb_w_data, wb_data_addr;
    rv32i_control_word wb_ctrl_word;
    logic [3:0]        wb_mbe;
    mem_state_t        mem_state;

    mem_access dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i), .pc_plus4_i(pc_plus4_i),
        .instruction_i(instruction_i), .ctrl_word_i(ctrl_word_i), .alu_i(alu_i),
        .rs2_i(rs2_i), .br_en_i(br_en_i), .freeze(freeze),
        .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
        .data_mbe(data_mbe), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_resp(data_resp), .stall_o(stall_o),
        .wb_pc(wb_pc), .wb_pc_plus4(wb_pc_plus4), .wb_instruction(wb_instruction),
        .wb_alu(wb_alu), .wb_br_en(wb_br_en), .wb_r_data(wb_r_data),
        .wb_w_data(wb_w_data), .wb_data_addr(wb_data_addr),
        .wb_ctrl_word(wb_ctrl_word), .wb_mbe(wb_mbe), .mem_state(mem_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [WB_W-1:0] exp_q[$];
    logic [WB_W-1:0] exp_wb = '0;
    logic [WB_W-1:0] wb_vec;
    rv32i_word  cur_addr, cur_wdata;
    logic [3:0] cur_mbe;
    rv32i_word  last_addr, last_wdata;
    logic [3:0] last_mbe;

    assign wb_vec = {wb_pc, wb_pc_plus4, wb_instruction, wb_ctrl_word, wb_alu, wb_br_en,
                     wb_r_data, wb_w_data, wb_data_addr, wb_mbe};

    task automatic chk(input string name, input logic [WB_W-1:0] act, input logic [WB_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] m_mbe(input logic [2:0] f3, input logic [1:0] off);
        int o, size;
        logic [3:0] m;
        o = int'(off);
        size = m_size(f3);
        m = '0;
        if (size == 4) return 4'hF;
        for (int i = 0; i < 4; i++)
            if (i >= o && i < o + size) m[i] = 1'b1;
        return m;
    endfunction

    function automatic rv32i_word m_wdata(input logic [2:0] f3, input logic [1:0] off, input rv32i_word rs2);
        int o, size;
        rv32i_word w;
        o = int'(off);
        size = m_size(f3);
        w = '0;
        if (size == 4) return rs2;
        for (int i = 0; i < 4; i++)
            if (i >= o && i < o + size) w[8*i +: 8] = rs2[8*(i-o) +: 8];
        return w;
    endfunction

    // ---------------- driver tasks ----------------
    // One cycle: inputs already driven; check comb outputs at negedge,
    // then check the MEM/WB register just after the following posedge.
    task automatic step(input bit e_rd, input bit e_wr, input bit e_stall, input bit retire);
        @(negedge clk);
        chk("data_read", data_read, e_rd);
        chk("data_write", data_write, e_wr);
        chk("stall_o", stall_o, e_stall);
        if (e_rd || e_wr) begin
            chk("data_addr", data_addr, cur_addr);
            chk("data_mbe", data_mbe, cur_mbe);
            if (e_wr) chk("data_wdata", data_wdata, cur_wdata);
            last_addr  = data_addr;
            last_mbe   = data_mbe;
            last_wdata = data_wdata;
        end
        @(posedge clk);
        #1;
        if (retire) begin
            if (exp_q.size() > 0) exp_wb = exp_q.pop_front();
            else chk("scoreboard_empty", 1, 0);
        end
        chk("wb_reg", wb_vec, exp_wb);
    endtask

    // f0: frozen cycles before issue; k: cycles from request to data_resp;
    // f1: frozen cycles starting on the data_resp cycle (needs k >= 1).
    task automatic run_instr(input bit v, input rv32i_opcode op, input logic [2:0] f3,
                             input rv32i_word alu, input rv32i_word rs2, input rv32i_word rdata,
                             input int k, input int f0, input int f1);
        bit mem, ld;
        rv32i_word pc, ins, br;
        logic [4:0] rd;
        pc  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        ins = $urandom;
        br  = $urandom_range(0, 1);
        rd  = 5'($urandom_range(1, 31));
        mem = v && (op == op_load || op == op_store);
        ld  = v && (op == op_load);
        valid_i       = v;
        pc_i          = pc;
        pc_plus4_i    = pc + 32'd4;
        instruction_i = ins;
        ctrl_word_i   = '{opcode: op, funct3: f3, load_regfile: (op != op_store), rd: rd};
        alu_i         = alu;
        rs2_i         = rs2;
        br_en_i       = br;
        cur_addr  = {alu[31:2], 2'b00};
        cur_mbe   = m_mbe(f3, alu[1:0]);
        cur_wdata = m_wdata(f3, alu[1:0], rs2);
        last_addr = '0; last_mbe = '0; last_wdata = '0;
        if (!v)
            exp_q.push_back('0);
        else if (mem)
            exp_q.push_back({pc, pc + 32'd4, ins, ctrl_word_i, alu, br, rdata, cur_wdata, cur_addr, cur_mbe});
        else
            exp_q.push_back({pc, pc + 32'd4, ins, ctrl_word_i, alu, br, 32'd0, 32'd0, 32'd0, 4'd0});

        data_resp = 1'b0;
        for (int i = 0; i < f0; i++) begin
            freeze = 1'b1;
            data_rdata = $urandom;
            step(0, 0, mem, 0);
        end
        freeze = 1'b0;
        if (!mem) begin
            step(0, 0, 0, 1);
        end else begin
            for (int c = 0; c <= k; c++) begin
                data_resp  = (c == k);
                data_rdata = (c == k) ? rdata : $urandom;
                freeze     = (c == k) && (f1 > 0);
                step(ld, !ld, c < k, (c == k) && (f1 == 0));
            end
            data_resp = 1'b0;
            if (f1 > 0) begin
                for (int j = 1; j < f1; j++) begin
                    freeze = 1'b1;
                    data_rdata = $urandom;
                    step(0, 0, 0, 0);
                end
                freeze = 1'b0;
                data_rdata = $urandom;
                step(0, 0, 0, 1);
            end
        end
        data_resp = 1'b0;
        freeze = 1'b0;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        bit         st;
        logic [2:0] f3;
        rv32i_word  alu, rs2, rdata;
        int         k;
        logic [3:0] e_mbe;
        rv32i_word  e_wdata, e_addr;
    } vec_t;

    vec_t vecs[8];

    logic [2:0] ld_f3s[5];
    logic [2:0] st_f3s[3];

    initial begin
        int n_rand;
        rv32i_opcode op;
        logic [2:0] f3;
        int kind, k, f0, f1;

        ld_f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        st_f3s = '{3'b000, 3'b001, 3'b010};
        vecs[0] = '{1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        3, 4'b1111, 32'hDEADBEEF, 32'h100};
        vecs[1] = '{1, 3'b000, 32'h103, 32'h123456AB, 32'h0,        1, 4'b1000, 32'hAB000000, 32'h100};
        vecs[2] = '{0, 3'b001, 32'h202, 32'h0,        32'h8001CAFE, 0, 4'b1100, 32'h0,        32'h200};
        vecs[3] = '{1, 3'b001, 32'h103, 32'h0000BEEF, 32'h0,        0, 4'b1000, 32'hEF000000, 32'h100};
        vecs[4] = '{1, 3'b001, 32'h201, 32'h00001234, 32'h0,        2, 4'b0110, 32'h00123400, 32'h200};
        vecs[5] = '{1, 3'b000, 32'h010, 32'h000000FF, 32'h0,        0, 4'b0001, 32'h000000FF, 32'h010};
        vecs[6] = '{0, 3'b100, 32'h007, 32'h0,        32'h11223344, 1, 4'b1000, 32'h0,        32'h004};
        vecs[7] = '{0, 3'b010, 32'h7FF, 32'h0,        32'h55AA55AA, 2, 4'b1111, 32'h0,        32'h7FC};

        // Reset: all outputs zero asynchronously, even with a store presented.
        valid_i = 1'b1;
        ctrl_word_i = '{opcode: op_store, funct3: 3'b010, load_regfile: 1'b0, rd: 5'd3};
        alu_i = 32'h40;
        rs2_i = 32'hFFFF_FFFF;
        #2;
        chk("rst_data_write", data_write, 0);
        chk("rst_data_read", data_read, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_data_addr", data_addr, 0);
        chk("rst_data_mbe", data_mbe, 0);
        chk("rst_data_wdata", data_wdata, 0);
        chk("rst_wb", wb_vec, 0);
        chk("rst_state", mem_state, MEM_IDLE);
        @(posedge clk);
        #1;
        rst = 1'b1;
        valid_i = 1'b0;
        exp_wb = '0;

        // Table-driven alignment vectors.
        foreach (vecs[i]) begin
            run_instr(1, vecs[i].st ? op_store : op_load, vecs[i].f3, vecs[i].alu,
                      vecs[i].rs2, vecs[i].rdata, vecs[i].k, 0, 0);
            chk("tbl_mbe", last_mbe, vecs[i].e_mbe);
            chk("tbl_addr", last_addr, vecs[i].e_addr);
            chk("tbl_wb_mbe", wb_mbe, vecs[i].e_mbe);
            if (vecs[i].st) begin
                chk("tbl_wdata", last_wdata, vecs[i].e_wdata);
                chk("tbl_wb_w_data", wb_w_data, vecs[i].e_wdata);
            end else begin
                chk("tbl_wb_r_data", wb_r_data, vecs[i].rdata);
            end
        end

        // Back-to-back add then bubble.
        run_instr(1, op_reg, 3'b000, 32'h1234_5678, 32'h9, 32'h0, 0, 0, 0);
        run_instr(0, op_reg, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        chk("bubble_load_regfile", wb_ctrl_word.load_regfile, 0);

        // lw with freeze on the response cycle and two more cycles.
        run_instr(1, op_load, 3'b010, 32'h300, 32'h0, 32'hA5A5_1234, 1, 0, 3);
        chk("hold_r_data", wb_r_data, 32'hA5A5_1234);

        // Freeze in IDLE delays issue; then a store with a held response.
        run_instr(1, op_store, 3'b000, 32'h402, 32'h77, 32'h0, 2, 2, 1);

        // Reset during WAIT drops the request immediately.
        run_instr(1, op_imm, 3'b000, 32'hCAFE_0001, 32'h0, 32'h0, 0, 0, 0);
        valid_i = 1'b1;
        ctrl_word_i = '{opcode: op_load, funct3: 3'b010, load_regfile: 1'b1, rd: 5'd7};
        alu_i = 32'h500;
        data_resp = 1'b0;
        @(posedge clk);
        #1;
        #1;
        chk("wait_data_read", data_read, 1);
        rst = 1'b0;
        #1;
        chk("rstwait_data_read", data_read, 0);
        chk("rstwait_stall", stall_o, 0);
        chk("rstwait_ctrl", wb_ctrl_word, 0);
        chk("rstwait_wb", wb_vec, 0);
        exp_q.delete();
        exp_wb = '0;
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_instr(0, op_reg, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0, 0);

        // Randomized instructions.
        n_rand = 60;
        for (int n = 0; n < n_rand; n++) begin
            kind = $urandom_range(0, 99);
            k  = $urandom_range(0, 3);
            f0 = $urandom_range(0, 1);
            f1 = (k > 0) ? $urandom_range(0, 2) : 0;
            if (kind < 15) begin
                run_instr(0, op_reg, 3'b000, $urandom, $urandom, 32'h0, 0, f0, 0);
            end else if (kind < 45) begin
                op = (kind < 30) ? op_reg : op_imm;
                f3 = 3'($urandom_range(0, 7));
                run_instr(1, op, f3, $urandom, $urandom, 32'h0, 0, f0, 0);
            end else if (kind < 75) begin
                f3 = ld_f3s[$urandom_range(0, 4)];
                run_instr(1, op_load, f3, $urandom, $urandom, $urandom, k, f0, f1);
            end else begin
                f3 = st_f3s[$urandom_range(0, 2)];
                run_instr(1, op_store, f3, $urandom, $urandom, $urandom, k, f0, f1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access (MEM) stage of the RV32I pipeline, between the EX/MEM register and the write-back stage. It turns load/store instructions into data-cache requests (aligned address, byte mask, lane-shifted store data), stalls the pipeline until the cache responds, and owns the MEM/WB pipeline register that feeds write-back. Non-memory instructions pass through in one cycle.

## Interface
- No parameters; widths fixed by `rv32i_types` (`rv32i_word` = 32 bits).
- `clk`  in  1  pipeline clock.
- `rst`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  EX/MEM holds a real instruction (0 = bubble).
- `pc_i`, `pc_plus4_i`, `instruction_i`  in  32 each  from EX/MEM.
- `ctrl_word_i`  in  `rv32i_control_word`  from EX/MEM; uses `opcode`, `funct3`, `load_regfile`, `rd`.
- `alu_i`  in  32  ALU result; the effective address for loads/stores.
- `rs2_i`  in  32  store source data.
- `br_en_i`  in  32  branch compare result, passed through.
- `freeze`  in  1  global stall from outside this stage (e.g. instruction fetch miss).
- `data_read`, `data_write`  out  1 each  cache request strobes.
- `data_addr`  out  32  `{alu_i[31:2], 2'b00}`.
- `data_mbe`  out  4  byte mask.
- `data_wdata`  out  32  lane-shifted store data.
- `data_rdata`  in  32  cache read data, valid with `data_resp`.
- `data_resp`  in  1  one-cycle cache completion pulse.
- `stall_o`  out  1  MEM cannot retire this cycle; EX/MEM and earlier hold.
- `wb_pc`, `wb_pc_plus4`, `wb_instruction`, `wb_alu`, `wb_br_en`, `wb_r_data`, `wb_w_data`, `wb_data_addr`  out  32 each  MEM/WB register.
- `wb_ctrl_word`  out  `rv32i_control_word`  MEM/WB register.
- `wb_mbe`  out  4  MEM/WB register.

## Operation
- `mem_op` = `valid_i` and opcode is `op_load` or `op_store`.
- Byte mask comes from `funct3` and `off = alu_i[1:0]`:
  - byte: `4'b0001 << off`.
  - half: `4'b0011 << off`, truncated to 4 bits, so off=3 gives `4'b1000`.
  - word: `4'b1111`.
- Store data:
  - sb: `rs2_i[7:0]` shifted by `8*off`.
  - sh: `rs2_i[15:0]` shifted by `8*off`, truncated.
  - sw: `rs2_i` unchanged.
  - Unselected lanes are 0.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE: if `mem_op` and not `freeze`, assert `data_read` (load) or `data_write` (store) combinationally.
    - `data_resp` the same cycle: complete now.
    - Otherwise go to WAIT.
  - WAIT: strobe, address, mask and wdata stay asserted and stable.
    - `data_resp` with `freeze`=0: complete, go to IDLE.
    - `data_resp` with `freeze`=1: latch `data_rdata` into the hold buffer, drop the strobe, go to HOLD.
  - HOLD: no strobe. When `freeze`=0, load MEM/WB from the hold buffer and go to IDLE.
- `stall_o` = (IDLE and `mem_op` and not `data_resp`) or (WAIT and not `data_resp`).
- MEM/WB load enable = not `stall_o` and not `freeze`.
  - On load: copy the pass-through fields.
  - `wb_r_data` = `data_rdata` (or the hold buffer), raw; write-back does the extension.
  - `wb_w_data` = shifted store data.
  - `wb_mbe` = byte mask.
  - `wb_data_addr` = aligned address.
  - For non-memory instructions, `wb_mbe`, `wb_r_data`, `wb_w_data` and `wb_data_addr` are 0.
- A bubble (`valid_i`=0) loads an all-zero MEM/WB entry, so `wb_ctrl_word.load_regfile`=0.
- When MEM/WB is not loaded it holds its value; write-back must never see a duplicate write, because the enable gates the load.

## Timing
- Reset, immediate and asynchronous:
  - State IDLE; hold buffer 0.
  - All `wb_*` outputs 0.
  - `data_read`, `data_write`, `stall_o` 0; `data_addr`, `data_mbe`, `data_wdata` 0.
- Reset mid-WAIT drops the request immediately. The cache is reset by the same `rst`.
- Non-memory instruction: visible on `wb_*` at the next rising edge (1-cycle latency).
- Memory instruction whose `data_resp` arrives k cycles after the request starts: `stall_o` is high for k cycles, and `wb_*` update at the edge ending the `data_resp` cycle.
- Exactly one cache transaction per memory instruction, including when `freeze` overlaps the access.
- `freeze` in IDLE stops a new request from issuing.

## Structure
- Add the `mem_state_t` enum (IDLE/WAIT/HOLD) to `rv32i_types`. The load/store `funct3` enums already live there.
- Sub-module `mem_align` (combinational): `funct3`, `off`, `rs2` → `mbe`, `wdata`. It is instantiated once here and unit-tested alone.

## Test plan
- sw, `alu_i`=0x100, `rs2_i`=0xDEADBEEF, `data_resp` 3 cycles later → `data_write`=1, `data_addr`=0x100, `data_mbe`=1111, `data_wdata`=0xDEADBEEF; `stall_o` high 3 cycles; then `wb_w_data`=0xDEADBEEF, `wb_mbe`=1111.
- sb, `alu_i`=0x103, `rs2_i`=0x123456AB → `data_mbe`=1000, `data_wdata`=0xAB000000, `data_addr`=0x100.
- lh, `alu_i`=0x202, `data_rdata`=0x8001CAFE, same-cycle `data_resp` → `data_mbe`=1100, `stall_o` never high, `wb_r_data`=0x8001CAFE, `wb_mbe`=1100.
- lw with `freeze`=1 on the `data_resp` cycle and for 2 more cycles → strobe drops after `data_resp`, `wb_*` unchanged for 3 edges, then `wb_r_data` = buffered data; exactly one `data_read` transaction.
- `rst` pulled low during WAIT → `data_read`=0 and `wb_ctrl_word`=0 without waiting for a clock edge.
- Back-to-back add and bubble → each appears on `wb_*` one cycle later, the bubble with `load_regfile`=0; `data_read`/`data_write` stay 0.
